// File: rtl/cpu_muldiv_iter_if.sv
// cpu_muldiv_iter_if: start/busy/done handshake and operand/result bus
// between the CPU pipeline (master) and the iterative M-extension unit (slave).
interface cpu_muldiv_iter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  MD_Start;
    logic                  MD_Flush;
    logic [2:0]            MD_Funct3;
    logic [DATA_WIDTH-1:0] MD_Op1;
    logic [DATA_WIDTH-1:0] MD_Op2;
    logic                  MD_Busy;
    logic                  MD_Done;
    logic [DATA_WIDTH-1:0] MD_Result;

    // CPU side: issues requests, stalls on busy, collects the result
    modport master (
        output MD_Start,
        output MD_Flush,
        output MD_Funct3,
        output MD_Op1,
        output MD_Op2,
        input  MD_Busy,
        input  MD_Done,
        input  MD_Result
    );

    // Unit side: consumes requests, reports progress and result
    modport slave (
        input  MD_Start,
        input  MD_Flush,
        input  MD_Funct3,
        input  MD_Op1,
        input  MD_Op2,
        output MD_Busy,
        output MD_Done,
        output MD_Result
    );
endinterface

// File: rtl/cpu_muldiv_iter.sv
// cpu_muldiv_iter: iterative RV32M multiply/divide unit.
// Operands are reduced to magnitudes when a request is accepted; the core
// then resolves one multiplier bit (shift-add) or one quotient bit
// (restoring division) per cycle and re-applies the sign on the last step.
// Divide-by-zero and signed overflow skip the iteration and go straight to
// DONE with a preloaded result. All outputs come straight from flops.
module cpu_muldiv_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic              CPU_clk,
    input  logic              CPU_rst_n,
    cpu_muldiv_iter_if.slave  md
);
    localparam int W = DATA_WIDTH;

    localparam logic [W-1:0]         ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0]         ONES_W   = {W{1'b1}};
    localparam logic [W-1:0]         MIN_W    = {1'b1, {(W-1){1'b0}}};
    localparam logic [2*W-1:0]       ZERO_2W  = {(2*W){1'b0}};
    localparam logic [W:0]           ZERO_W1  = {(W+1){1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Two's complement negation of a W-bit value
    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        return ~v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement negation of a 2W-bit value
    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
        return ~v + {{(2*W-1){1'b0}}, 1'b1};
    endfunction

    // Architectural and working state
    state_t                 state_q;
    logic [2:0]             funct3_q;
    logic [W-1:0]           mcand_q;     // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*W-1:0]         acc_q;       // {high, multiplier} for MUL; low half is dividend/quotient for DIV
    logic [W:0]             rem_q;       // partial remainder of the restoring divider
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   neg_res_q;   // product/quotient must be negated
    logic                   neg_rem_q;   // remainder must be negated (dividend was negative)
    logic [W-1:0]           res_q;       // final result staged for DONE
    logic                   busy_q;
    logic                   done_q;
    logic [W-1:0]           result_q;

    // Request decode, computed from the live inputs and used only in IDLE
    logic                   op1_signed_s;
    logic                   op2_signed_s;
    logic                   op1_neg_s;
    logic                   op2_neg_s;
    logic [W-1:0]           op1_mag_s;
    logic [W-1:0]           op2_mag_s;
    logic                   div_zero_s;
    logic                   div_ovf_s;
    logic                   special_s;
    logic [W-1:0]           special_res_s;

    // Iteration datapath
    logic [W:0]             mul_sum_s;
    logic [2*W-1:0]         mul_acc_s;
    logic [2*W-1:0]         mul_prod_s;
    logic [W-1:0]           mul_result_s;
    logic [W+1:0]           div_trial_s;
    logic [W+1:0]           div_diff_s;
    logic                   div_bit_s;
    logic [W:0]             div_rem_s;
    logic [W-1:0]           div_quo_s;
    logic [W-1:0]           div_result_s;
    logic [W-1:0]           iter_result_s;

    // Decode operand signedness, magnitudes and the divider special cases
    always_comb begin
        op1_signed_s  = 1'b0;
        op2_signed_s  = 1'b0;
        op1_mag_s     = md.MD_Op1;
        op2_mag_s     = md.MD_Op2;
        special_res_s = ONES_W;
        case (md.MD_Funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b1;
            end
            3'b010: begin
                op1_signed_s = 1'b1;
                op2_signed_s = 1'b0;
            end
            default: begin
                op1_signed_s = 1'b0;
                op2_signed_s = 1'b0;
            end
        endcase
        op1_neg_s = op1_signed_s & md.MD_Op1[W-1];
        op2_neg_s = op2_signed_s & md.MD_Op2[W-1];
        if (op1_neg_s) begin
            op1_mag_s = neg_w(md.MD_Op1);
        end else begin
            op1_mag_s = md.MD_Op1;
        end
        if (op2_neg_s) begin
            op2_mag_s = neg_w(md.MD_Op2);
        end else begin
            op2_mag_s = md.MD_Op2;
        end
        div_zero_s = (md.MD_Op2 == ZERO_W);
        // Only the signed forms (DIV/REM, funct3[0]=0) can overflow
        div_ovf_s  = ~md.MD_Funct3[0] & (md.MD_Op1 == MIN_W) & (md.MD_Op2 == ONES_W);
        special_s  = md.MD_Funct3[2] & (div_zero_s | div_ovf_s);
        if (div_zero_s) begin
            if (md.MD_Funct3[1]) begin
                special_res_s = md.MD_Op1;
            end else begin
                special_res_s = ONES_W;
            end
        end else begin
            if (md.MD_Funct3[1]) begin
                special_res_s = ZERO_W;
            end else begin
                special_res_s = MIN_W;
            end
        end
    end

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole accumulator right
    always_comb begin
        if (acc_q[0]) begin
            mul_sum_s = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[2*W-1:W]};
        end
        mul_acc_s = {mul_sum_s, acc_q[W-1:1]};
        if (neg_res_q) begin
            mul_prod_s = neg_2w(mul_acc_s);
        end else begin
            mul_prod_s = mul_acc_s;
        end
        if (funct3_q[1:0] == 2'b00) begin
            mul_result_s = mul_prod_s[W-1:0];
        end else begin
            mul_result_s = mul_prod_s[2*W-1:W];
        end
    end

    // One restoring-division step: shift in the next dividend bit, try to
    // subtract the divisor, keep the difference only if it did not go negative
    always_comb begin
        div_trial_s = {rem_q, acc_q[W-1]};
        div_diff_s  = div_trial_s - {2'b00, mcand_q};
        div_bit_s   = ~div_diff_s[W+1];
        if (div_bit_s) begin
            div_rem_s = div_diff_s[W:0];
        end else begin
            div_rem_s = div_trial_s[W:0];
        end
        div_quo_s = {acc_q[W-2:0], div_bit_s};
        if (funct3_q[1]) begin
            if (neg_rem_q) begin
                div_result_s = neg_w(div_rem_s[W-1:0]);
            end else begin
                div_result_s = div_rem_s[W-1:0];
            end
        end else begin
            if (neg_res_q) begin
                div_result_s = neg_w(div_quo_s);
            end else begin
                div_result_s = div_quo_s;
            end
        end
        if (funct3_q[2]) begin
            iter_result_s = div_result_s;
        end else begin
            iter_result_s = mul_result_s;
        end
    end

    // Control FSM with all working registers and registered outputs
    always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n) begin
            state_q   <= ST_IDLE;
            funct3_q  <= 3'b000;
            mcand_q   <= ZERO_W;
            acc_q     <= ZERO_2W;
            rem_q     <= ZERO_W1;
            cnt_q     <= CNT_ZERO;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= ZERO_W;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= ZERO_W;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    // Flush wins over a simultaneous start
                    if (md.MD_Start && !md.MD_Flush) begin
                        funct3_q  <= md.MD_Funct3;
                        cnt_q     <= CNT_ZERO;
                        rem_q     <= ZERO_W1;
                        neg_res_q <= op1_neg_s ^ op2_neg_s;
                        neg_rem_q <= op1_neg_s;
                        if (md.MD_Funct3[2]) begin
                            mcand_q <= op2_mag_s;
                            acc_q   <= {ZERO_W, op1_mag_s};
                        end else begin
                            mcand_q <= op1_mag_s;
                            acc_q   <= {ZERO_W, op2_mag_s};
                        end
                        if (special_s) begin
                            res_q   <= special_res_s;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else if (md.MD_Funct3[2]) begin
                            busy_q  <= 1'b1;
                            state_q <= ST_DIV;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_MUL;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    done_q <= 1'b0;
                    if (md.MD_Flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= mul_acc_s;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            res_q   <= iter_result_s;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_MUL;
                        end
                    end
                end
                ST_DIV: begin
                    done_q <= 1'b0;
                    if (md.MD_Flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= {acc_q[2*W-1:W], div_quo_s};
                        rem_q <= div_rem_s;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            res_q   <= iter_result_s;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_DONE: begin
                    // Start and flush are both ignored here
                    result_q <= res_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign md.MD_Busy   = busy_q;
    assign md.MD_Done   = done_q;
    assign md.MD_Result = result_q;

endmodule

// File: tb/tb_cpu_muldiv_iter.sv
// tb_cpu_muldiv_iter: directed and randomized checks of the iterative
// multiply/divide unit against an arithmetic reference model.
module tb_cpu_muldiv_iter;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cpu_muldiv_iter_if #(.DATA_WIDTH(32)) m_if ();

    cpu_muldiv_iter #(.DATA_WIDTH(32)) dut (
        .CPU_clk   (clk),
        .CPU_rst_n (rst_n),
        .md        (m_if)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && b == 32'h0) ||
               ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference model: plain 64-bit arithmetic on the RV32M definitions
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = 64'h0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Issue one operation from a negedge and follow it to its Done pulse.
    // poke_c >= 0 pulses a conflicting start at that cycle of the operation.
    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int poke_c);
        int c;
        int busy_n;
        bit seen;
        bit sp;
        sp = is_special(f, a, b);
        m_if.MD_Funct3 = f;
        m_if.MD_Op1    = a;
        m_if.MD_Op2    = b;
        m_if.MD_Start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_if.MD_Start = 1'b0;
        check("done_low_at_start", {31'h0, m_if.MD_Done}, 32'h0);
        c      = 0;
        busy_n = 0;
        seen   = 1'b0;
        while (!seen && c < 100) begin
            if (m_if.MD_Busy) busy_n++;
            if (c == poke_c) begin
                m_if.MD_Start  = 1'b1;
                m_if.MD_Funct3 = ~f;
                m_if.MD_Op1    = ~a;
                m_if.MD_Op2    = b ^ 32'h5A5A_5A5A;
            end else begin
                m_if.MD_Start = 1'b0;
            end
            @(negedge clk);
            c++;
            if (m_if.MD_Done) seen = 1'b1;
        end
        m_if.MD_Start = 1'b0;
        check("done_seen", {31'h0, seen}, 32'h1);
        check("latency", 32'(c), sp ? 32'd1 : 32'd33);
        check("busy_cycles", 32'(busy_n), sp ? 32'd0 : 32'd32);
        check("result", m_if.MD_Result, exp);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          dn;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        m_if.MD_Start  = 1'b0;
        m_if.MD_Flush  = 1'b0;
        m_if.MD_Funct3 = 3'b000;
        m_if.MD_Op1    = 32'h0;
        m_if.MD_Op2    = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'h0, m_if.MD_Busy}, 32'h0);
        check("reset_done", {31'h0, m_if.MD_Done}, 32'h0);
        check("reset_result", m_if.MD_Result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed MUL and DIV families, issued back to back
        run(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, -1);
        run(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, -1);
        run(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
        run(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, -1);
        run(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, -1);
        run(3'd5, 32'd100,        32'd7,         32'd14,        -1);
        run(3'd7, 32'd100,        32'd7,         32'd2,         -1);

        // Special cases bypass the iteration
        run(3'd4, 32'h0000_1234,  32'h0,         32'hFFFF_FFFF, -1);
        run(3'd6, 32'h0000_1234,  32'h0,         32'h0000_1234, -1);
        run(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, -1);
        run(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         -1);
        run(3'd5, 32'h0000_1234,  32'h0,         32'hFFFF_FFFF, -1);
        run(3'd7, 32'h0000_1234,  32'h0,         32'h0000_1234, -1);

        // A start pulse while busy is ignored
        run(3'd3, 32'hDEAD_BEEF,  32'h1234_5678, ref_md(3'd3, 32'hDEAD_BEEF, 32'h1234_5678), 10);
        @(negedge clk);
        check("single_done_after_poke", {31'h0, m_if.MD_Done}, 32'h0);
        check("idle_after_poke", {31'h0, m_if.MD_Busy}, 32'h0);

        // Randomized operations with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'($urandom_range(0, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run(f, a, b, ref_md(f, a, b), -1);
        end

        // Known result to compare against in the abort tests
        run(3'd5, 32'd100, 32'd7, 32'd14, -1);

        // Flush together with start in IDLE drops the request
        m_if.MD_Funct3 = 3'd0;
        m_if.MD_Op1    = 32'd3;
        m_if.MD_Op2    = 32'd5;
        m_if.MD_Start  = 1'b1;
        m_if.MD_Flush  = 1'b1;
        @(negedge clk);
        m_if.MD_Start = 1'b0;
        m_if.MD_Flush = 1'b0;
        check("idle_flush_busy", {31'h0, m_if.MD_Busy}, 32'h0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_if.MD_Done) dn++;
        end
        check("idle_flush_no_done", 32'(dn), 32'h0);
        check("idle_flush_result", m_if.MD_Result, 32'd14);

        // Flush in the middle of a DIV
        m_if.MD_Funct3 = 3'd4;
        m_if.MD_Op1    = 32'hFFFF_0000;
        m_if.MD_Op2    = 32'd3;
        m_if.MD_Start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_if.MD_Start = 1'b0;
        repeat (15) @(negedge clk);
        check("div_busy_before_flush", {31'h0, m_if.MD_Busy}, 32'h1);
        m_if.MD_Flush = 1'b1;
        @(negedge clk);
        m_if.MD_Flush = 1'b0;
        check("flush_busy_falls", {31'h0, m_if.MD_Busy}, 32'h0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_if.MD_Done) dn++;
        end
        check("flush_no_done", 32'(dn), 32'h0);
        check("flush_result_kept", m_if.MD_Result, 32'd14);

        // Reset in the middle of a MUL
        m_if.MD_Funct3 = 3'd0;
        m_if.MD_Op1    = 32'd12345;
        m_if.MD_Op2    = 32'd678;
        m_if.MD_Start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_if.MD_Start = 1'b0;
        repeat (20) @(negedge clk);
        check("mul_busy_before_reset", {31'h0, m_if.MD_Busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'h0, m_if.MD_Busy}, 32'h0);
        check("midreset_done", {31'h0, m_if.MD_Done}, 32'h0);
        check("midreset_result", m_if.MD_Result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_if.MD_Done) dn++;
        end
        check("midreset_no_done", 32'(dn), 32'h0);

        // Unit is usable again after the reset
        run(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, ref_md(3'd1, 32'hFFFF_FFFE, 32'h0000_0003), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
